// File: rtl/energy_accumulator_pkg.sv
// Shared types and width helpers for the energy monitor datapath.
package energy_monitor_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_e;

  // A sum of dataspin signed local_bit values needs clog2(dataspin) extra bits.
  function automatic int energy_total_bit(input int dataspin, input int local_bit);
    return local_bit + $clog2(dataspin);
  endfunction

endpackage

// File: rtl/energy_sat_adder.sv
// Combinational signed adder producing a W-bit result from a W-bit and a BW-bit operand.
// ENERGY_ACC_SATURATE_EN clamps the result to the W-bit signed range; otherwise it wraps.
module energy_sat_adder #(
  parameter int W  = 18,
  parameter int BW = 16
) (
  input  logic signed [W-1:0]  a_i,
  input  logic signed [BW-1:0] b_i,
  output logic signed [W-1:0]  sum_o
);

`ifdef ENERGY_ACC_SATURATE_EN
  localparam int IW = ((W > BW) ? W : BW) + 1;
  localparam logic signed [IW-1:0] MAX_V = {{(IW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_V = {{(IW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [IW-1:0] sum_full;

  // The full-width sum is exact, so comparing it against the W-bit limits is safe.
  assign sum_full = {{(IW-W){a_i[W-1]}}, a_i} + {{(IW-BW){b_i[BW-1]}}, b_i};

  always_comb begin
    sum_o = sum_full[W-1:0];
    if (sum_full > MAX_V) begin
      sum_o = MAX_V[W-1:0];
    end else if (sum_full < MIN_V) begin
      sum_o = MIN_V[W-1:0];
    end
  end
`else
  assign sum_o = a_i + W'(b_i);
`endif

endmodule

// File: rtl/energy_accumulator.sv
// Accumulates DATASPIN signed partial energies into a total Ising energy over valid/ready handshakes.
// Optional macro ENERGY_ACC_SATURATE_EN selects clamping instead of wrapping on narrow totals.
module energy_accumulator
  import energy_monitor_pkg::*;
#(
  parameter int DATASPIN         = 256,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int ENERGY_TOTAL_BIT = energy_total_bit(DATASPIN, LOCAL_ENERGY_BIT),
  parameter int CNT_BIT          = $clog2(DATASPIN + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic                        busy_o,
  input  logic                        energy_valid_i,
  output logic                        energy_ready_o,
  input  logic [LOCAL_ENERGY_BIT-1:0] energy_i,
  output logic                        total_valid_o,
  input  logic                        total_ready_i,
  output logic [ENERGY_TOTAL_BIT-1:0] total_o,
  output logic [CNT_BIT-1:0]          count_o
);

  acc_state_e                         state_q, state_d;
  logic signed [ENERGY_TOTAL_BIT-1:0] acc_q, acc_d;
  logic signed [ENERGY_TOTAL_BIT-1:0] total_q, total_d;
  logic        [CNT_BIT-1:0]          count_q, count_d;
  logic signed [ENERGY_TOTAL_BIT-1:0] sum;

  energy_sat_adder #(
    .W  (ENERGY_TOTAL_BIT),
    .BW (LOCAL_ENERGY_BIT)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   ($signed(energy_i)),
    .sum_o (sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    total_d = total_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ACC;
          acc_d   = '0;
          count_d = '0;
        end
      end
      ACC: begin
        if (energy_valid_i) begin
          acc_d   = sum;
          count_d = count_q + CNT_BIT'(1);
          if (count_q == CNT_BIT'(DATASPIN - 1)) begin
            state_d = DONE;
            total_d = sum;
          end
        end
      end
      DONE: begin
        // A start arriving with the handshake chains straight into the next run.
        if (total_ready_i) begin
          if (start_i) begin
            state_d = ACC;
            acc_d   = '0;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      total_q <= total_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign energy_ready_o = (state_q == ACC);
  assign total_valid_o  = (state_q == DONE);
  assign total_o        = total_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_energy_accumulator.sv
// Directed self-checking bench for energy_accumulator with DATASPIN=4 (default and 4-bit total widths).
module tb_energy_accumulator;

  logic        clk = 1'b0;
  logic        rst;

  logic        start, e_valid, t_ready;
  logic [15:0] energy;
  logic        busy, e_ready, t_valid;
  logic [17:0] total;
  logic [2:0]  count;

  logic        start_n, e_valid_n, t_ready_n;
  logic [15:0] energy_n;
  logic        busy_n, e_ready_n, t_valid_n;
  logic [3:0]  total_n;
  logic [2:0]  count_n;

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 clk = ~clk;

  energy_accumulator #(.DATASPIN(4), .LOCAL_ENERGY_BIT(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy),
    .energy_valid_i(e_valid), .energy_ready_o(e_ready), .energy_i(energy),
    .total_valid_o(t_valid), .total_ready_i(t_ready), .total_o(total), .count_o(count)
  );

  energy_accumulator #(.DATASPIN(4), .LOCAL_ENERGY_BIT(16), .ENERGY_TOTAL_BIT(4)) dut_n (
    .clk_i(clk), .rst_i(rst), .start_i(start_n), .busy_o(busy_n),
    .energy_valid_i(e_valid_n), .energy_ready_o(e_ready_n), .energy_i(energy_n),
    .total_valid_o(t_valid_n), .total_ready_i(t_ready_n), .total_o(total_n), .count_o(count_n)
  );

  // Drive inputs, then advance one rising edge and settle before sampling.
  task automatic applyStimulus(input logic s, input logic v, input int e, input logic tr);
    start   = s;
    e_valid = v;
    energy  = 16'(e);
    t_ready = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      bad_checks++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkDone(input string tag, input int exp_total);
    checkOutput({tag, " valid"}, 32'(t_valid), 1);
    checkOutput({tag, " ready"}, 32'(e_ready), 0);
    checkOutput({tag, " total"}, 32'($signed(total)), exp_total);
    checkOutput({tag, " count"}, 32'(count), 4);
  endtask

  initial begin
    rst = 1'b1;
    start_n = 0; e_valid_n = 0; t_ready_n = 0; energy_n = '0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset ready", 32'(e_ready), 0);
    checkOutput("reset valid", 32'(t_valid), 0);
    checkOutput("reset total", 32'($signed(total)), 0);
    checkOutput("reset count", 32'(count), 0);
    rst = 1'b0;

    $display("[TB] back-to-back partials 3,-1,7,-2");
    applyStimulus(1, 0, 0, 0);
    checkOutput("t1 busy", 32'(busy), 1);
    checkOutput("t1 ready", 32'(e_ready), 1);
    applyStimulus(0, 1, 3, 0);
    applyStimulus(0, 1, -1, 0);
    applyStimulus(0, 1, 7, 0);
    checkOutput("t1 count3", 32'(count), 3);
    checkOutput("t1 early valid", 32'(t_valid), 0);
    applyStimulus(0, 1, -2, 0);
    checkDone("t1", 7);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t1 idle busy", 32'(busy), 0);
    checkOutput("t1 idle valid", 32'(t_valid), 0);

    $display("[TB] gapped partials and stalled consumer");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 3, 0);
    applyStimulus(0, 0, 50, 0);
    applyStimulus(0, 1, -1, 0);
    applyStimulus(0, 0, 50, 0);
    applyStimulus(0, 1, 7, 0);
    applyStimulus(0, 1, -2, 0);
    checkDone("t2 first", 7);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 2, 1, 100, 0);
      checkDone("t2 hold", 7);
    end
    applyStimulus(0, 1, 100, 1);
    checkOutput("t2 idle busy", 32'(busy), 0);
    checkOutput("t2 idle ready", 32'(e_ready), 0);
    applyStimulus(0, 1, 100, 1);
    checkOutput("t2 idle count", 32'(count), 4);
    checkOutput("t2 idle total", 32'($signed(total)), 7);
    checkOutput("t2 idle valid", 32'(t_valid), 0);

    $display("[TB] chained restart on handshake");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 2, 0);
    checkOutput("t3 start in acc", 32'(count), 2);
    applyStimulus(0, 1, 3, 0);
    applyStimulus(0, 1, 4, 0);
    checkDone("t3 first", 10);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t3 chain busy", 32'(busy), 1);
    checkOutput("t3 chain ready", 32'(e_ready), 1);
    checkOutput("t3 chain count", 32'(count), 0);
    checkOutput("t3 chain valid", 32'(t_valid), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, -5, 0);
    checkDone("t3 second", -20);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] reset mid-run");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 10, 0);
    applyStimulus(0, 1, 20, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("t4 busy", 32'(busy), 0);
    checkOutput("t4 ready", 32'(e_ready), 0);
    checkOutput("t4 valid", 32'(t_valid), 0);
    checkOutput("t4 total", 32'($signed(total)), 0);
    checkOutput("t4 count", 32'(count), 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0);
    checkDone("t4 fresh", 4);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] narrow 4-bit total with partials 7,7,-16,0");
    start_n = 1;
    @(posedge clk); #1;
    start_n = 0;
    e_valid_n = 1;
    energy_n = 16'sd7;  @(posedge clk); #1;
    energy_n = 16'sd7;  @(posedge clk); #1;
    energy_n = -16'sd16; @(posedge clk); #1;
    energy_n = 16'sd0;  @(posedge clk); #1;
    e_valid_n = 0;
    checkOutput("t5 valid", 32'(t_valid_n), 1);
    checkOutput("t5 count", 32'(count_n), 4);
`ifdef ENERGY_ACC_SATURATE_EN
    checkOutput("t5 total sat", 32'($signed(total_n)), -8);
`else
    checkOutput("t5 total wrap", 32'($signed(total_n)), -2);
`endif

    $display("[TB] test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
